// File: rtl/nested_loop_pkg.sv
// nested_loop_pkg: shared types and helpers for the nested loop index sequencer.
// Holds the sequencer state encoding, the default index width and the
// last-index compare used by each bounded counter.
package nested_loop_pkg;

   localparam int IDX_W_DEF = 8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RUN  = 2'b01,
      ST_DONE = 2'b10
   } state_e;

   // True when idx is the final value for bound lim, i.e. idx == lim-1 taken
   // modulo 2^w. Only meaningful for lim >= 1 (a zero bound never enters RUN).
   // The subtraction is done at w bits so the largest bound 2^w-1 compares
   // against 2^w-2 with no carry out of the index width.
   function automatic logic idx_is_last(input logic [31:0] idx,
                                        input logic [31:0] lim,
                                        input int unsigned w);
      logic [31:0] mask;
      mask = (32'd1 << w) - 32'd1;
      return ((idx & mask) == ((lim - 32'd1) & mask));
   endfunction

endpackage

// File: rtl/loop_idx_ctr.sv
// loop_idx_ctr: one bounded up-counter for a loop level of nested_loop_seq.
// Latency: idx_o updates on the clock edge after load_i/en_i; last_o/wrap_o are combinational.
// Backpressure: none of its own; the parent gates en_i with the output handshake.
// Ports:
//   clk, rst_n   clock, async active-low reset
//   load_i       clear index to 0 and latch lim_i as the bound (wins over en_i)
//   lim_i        bound to latch
//   en_i         advance one step
//   sat_i        on the last value, hold instead of wrapping back to 0
//   idx_o        current index
//   last_o       idx_o == latched bound - 1
//   wrap_o       en_i on the last value (a full pass of this level completed)
module loop_idx_ctr
   import nested_loop_pkg::*;
#(
   parameter int W = IDX_W_DEF
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load_i,
   input  logic [W-1:0] lim_i,
   input  logic         en_i,
   input  logic         sat_i,
   output logic [W-1:0] idx_o,
   output logic         last_o,
   output logic         wrap_o
);

   logic [W-1:0] idx_q, idx_d;
   logic [W-1:0] lim_q, lim_d;

   assign last_o = idx_is_last(32'(idx_q), 32'(lim_q), W);
   assign wrap_o = en_i & last_o;
   assign idx_o  = idx_q;

   always_comb begin
      idx_d = idx_q;
      lim_d = lim_q;
      if (load_i) begin
         idx_d = '0;
         lim_d = lim_i;
      end else if (en_i) begin
         if (last_o) begin
            idx_d = sat_i ? idx_q : '0;
         end else begin
            idx_d = idx_q + W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx_q <= '0;
         lim_q <= '0;
      end else begin
         idx_q <= idx_d;
         lim_q <= lim_d;
      end
   end

endmodule

// File: rtl/nested_loop_seq.sv
// nested_loop_seq: two-level loop index sequencer, emits (i,j) pairs with j innermost.
// Latency: first pair valid 1 cycle after an accepted start; one pair per cycle when idx_ready=1.
// Backpressure: idx_i/idx_j/iter_count hold while idx_valid=1 and idx_ready=0.
// Ports:
//   clk, rst               clock, async active-low reset
//   start                  begin a sequence (accepted only in IDLE or DONE)
//   outer_lim, inner_lim   loop bounds, latched on accepted start
//   idx_i, idx_j           current outer/inner index
//   idx_valid, idx_ready   output stream handshake
//   busy                   sequence running
//   finish                 level, sequence complete until next accepted start
//   iter_count             pairs accepted in the current or last sequence
// Optional build macro LOOP_ABORT_EN adds input abort and output aborted.
module nested_loop_seq
   import nested_loop_pkg::*;
#(
   parameter int IDX_W = IDX_W_DEF,
   parameter int CNT_W = 2 * IDX_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [IDX_W-1:0] outer_lim,
   input  logic [IDX_W-1:0] inner_lim,
   output logic [IDX_W-1:0] idx_i,
   output logic [IDX_W-1:0] idx_j,
   output logic             idx_valid,
   input  logic             idx_ready,
`ifdef LOOP_ABORT_EN
   input  logic             abort,
   output logic             aborted,
`endif
   output logic             busy,
   output logic             finish,
   output logic [CNT_W-1:0] iter_count
);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] iter_count_q, iter_count_d;

   logic start_acc;
   logic zero_lim;
   logic hs;
   logic abort_req;
   logic in_last, in_wrap;
   logic out_last, out_wrap;

   assign start_acc = start & (state_q != ST_RUN);
   assign zero_lim  = (outer_lim == '0) | (inner_lim == '0);
   assign hs        = (state_q == ST_RUN) & idx_ready;

`ifdef LOOP_ABORT_EN
   logic aborted_q, aborted_d;
   assign abort_req = abort & (state_q == ST_RUN);
   assign aborted   = aborted_q;
`else
   assign abort_req = 1'b0;
`endif

   // Inner level advances on every handshake. It saturates on the final pair
   // (outer also on its last value) so the indices keep their last values in DONE.
   loop_idx_ctr #(.W(IDX_W)) u_inner (
      .clk    (clk),
      .rst_n  (rst),
      .load_i (start_acc),
      .lim_i  (inner_lim),
      .en_i   (hs),
      .sat_i  (out_last),
      .idx_o  (idx_j),
      .last_o (in_last),
      .wrap_o (in_wrap)
   );

   // Outer level steps when the inner level completes a pass. Its wrap is
   // exactly the handshake of the final pair, so it never needs to roll over.
   loop_idx_ctr #(.W(IDX_W)) u_outer (
      .clk    (clk),
      .rst_n  (rst),
      .load_i (start_acc),
      .lim_i  (outer_lim),
      .en_i   (in_wrap),
      .sat_i  (1'b1),
      .idx_o  (idx_i),
      .last_o (out_last),
      .wrap_o (out_wrap)
   );

   always_comb begin
      state_d      = state_q;
      iter_count_d = iter_count_q;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start_acc) begin
               iter_count_d = '0;
               state_d      = zero_lim ? ST_DONE : ST_RUN;
            end
         end
         ST_RUN: begin
            if (hs) begin
               iter_count_d = iter_count_q + CNT_W'(1);
            end
            // A handshake in the same cycle as abort is still counted above.
            if (out_wrap || abort_req) begin
               state_d = ST_DONE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

`ifdef LOOP_ABORT_EN
   always_comb begin
      aborted_d = aborted_q;
      if (start_acc) begin
         aborted_d = 1'b0;
      end else if (abort_req) begin
         aborted_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         aborted_q <= 1'b0;
      end else begin
         aborted_q <= aborted_d;
      end
   end
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= ST_IDLE;
         iter_count_q <= '0;
      end else begin
         state_q      <= state_d;
         iter_count_q <= iter_count_d;
      end
   end

   assign idx_valid  = (state_q == ST_RUN);
   assign busy       = (state_q == ST_RUN);
   assign finish     = (state_q == ST_DONE);
   assign iter_count = iter_count_q;

endmodule
